// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer sample filter: default widths
// and the window FSM state encoding.
package accel_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int AVG_LOG2_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/accel_axis_acc.sv
// Per-axis window accumulator: sums samples, produces the floored window
// average and optionally flags a large change against the previous average.
// Optional feature macro: ACCEL_MOTION_DETECT_EN (adds the delta compare).
module accel_axis_acc
  import accel_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int AVG_LOG2      = AVG_LOG2_DEF,
  parameter int MOTION_THRESH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     accept,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] filt
`ifdef ACCEL_MOTION_DETECT_EN
  ,
  output logic                     over
`endif
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] avg;

  // Running sum including the current sample and its floored average.
  always_comb begin
    sum     = acc + {{AVG_LOG2{sample[DATA_W-1]}}, sample};
    shifted = sum >>> AVG_LOG2;
    avg     = shifted[DATA_W-1:0];
  end

  // Accumulator restarts on reset/clear and after each completed window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= last ? '0 : sum;
    end
  end

  // Average output only moves when a window completes; clear leaves it held.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
    end else if (accept && last) begin
      filt <= avg;
    end
  end

`ifdef ACCEL_MOTION_DETECT_EN
  localparam logic [DATA_W:0] THRESH = (DATA_W+1)'(MOTION_THRESH);

  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] mag;

  // One extra bit keeps the difference of two DATA_W values exact.
  always_comb begin
    diff = {avg[DATA_W-1], avg} - {filt[DATA_W-1], filt};
    mag  = diff[DATA_W] ? -diff : diff;
    over = (mag > THRESH);
  end
`endif

endmodule

// File: rtl/accel_sample_filter.sv
// Accelerometer box-car filter: averages 2^AVG_LOG2 samples per axis and
// reports a strobe per completed window.
// Optional feature macro: ACCEL_MOTION_DETECT_EN (motion strobe).
//
// state | meaning
// ------+--------------------------------------------------
// FILL  | first window since reset/clear, no prior average
// RUN   | a previous window average is held in Filt*
module accel_sample_filter
  import accel_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int AVG_LOG2      = AVG_LOG2_DEF,
  parameter int MOTION_THRESH = 64
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] AccelX,
  input  logic signed [DATA_W-1:0] AccelY,
  input  logic signed [DATA_W-1:0] AccelZ,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] FiltX,
  output logic signed [DATA_W-1:0] FiltY,
  output logic signed [DATA_W-1:0] FiltZ,
  output logic                     filt_valid,
  output logic                     motion
);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 6 || MOTION_THRESH < 0) begin : g_param_chk
    $error("accel_sample_filter: illegal AVG_LOG2 or MOTION_THRESH");
  end

  state_t              state;
  state_t              state_next;
  logic [AVG_LOG2-1:0] cnt;
  logic                accept;
  logic                last;
  logic                complete;

  // clear wins over a coincident sample, so the sample is never accepted.
  assign accept   = sample_valid & ~clear;
  assign last     = (cnt == '1);
  assign complete = accept & last;

  // Sample counter wraps naturally at the window size.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: first completed window moves to RUN, clear returns to FILL.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else if (complete) begin
      state_next = RUN;
    end
  end

  // Window-complete strobe, one cycle after the completing sample.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      filt_valid <= 1'b0;
    end else begin
      filt_valid <= complete;
    end
  end

`ifdef ACCEL_MOTION_DETECT_EN
  logic over_x;
  logic over_y;
  logic over_z;

  // Motion only makes sense against a real previous average, hence RUN only.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      motion <= 1'b0;
    end else begin
      motion <= complete && (state == RUN) && (over_x || over_y || over_z);
    end
  end
`else
  assign motion = 1'b0;
`endif

  accel_axis_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .MOTION_THRESH(MOTION_THRESH)) u_acc_x (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clear  (clear),
    .accept (accept),
    .last   (last),
    .sample (AccelX),
    .filt   (FiltX)
`ifdef ACCEL_MOTION_DETECT_EN
    ,
    .over   (over_x)
`endif
  );

  accel_axis_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .MOTION_THRESH(MOTION_THRESH)) u_acc_y (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clear  (clear),
    .accept (accept),
    .last   (last),
    .sample (AccelY),
    .filt   (FiltY)
`ifdef ACCEL_MOTION_DETECT_EN
    ,
    .over   (over_y)
`endif
  );

  accel_axis_acc #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .MOTION_THRESH(MOTION_THRESH)) u_acc_z (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .clear  (clear),
    .accept (accept),
    .last   (last),
    .sample (AccelZ),
    .filt   (FiltZ)
`ifdef ACCEL_MOTION_DETECT_EN
    ,
    .over   (over_z)
`endif
  );

endmodule

// File: tb/tb_accel_sample_filter.sv
// Directed self-checking bench for accel_sample_filter (default parameters).
module tb_accel_sample_filter;

  localparam int DW  = 12;
  localparam int WIN = 8;

  logic                 CLOCK_50 = 1'b0;
  logic                 RESET    = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] AccelX = '0;
  logic signed [DW-1:0] AccelY = '0;
  logic signed [DW-1:0] AccelZ = '0;
  logic                 clear = 1'b0;
  logic signed [DW-1:0] FiltX;
  logic signed [DW-1:0] FiltY;
  logic signed [DW-1:0] FiltZ;
  logic                 filt_valid;
  logic                 motion;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_cnt   = 0;
  int fv_last  = 0;
  int fv_prev  = 0;
  int base;

  accel_sample_filter dut (
    .CLOCK_50     (CLOCK_50),
    .RESET        (RESET),
    .sample_valid (sample_valid),
    .AccelX       (AccelX),
    .AccelY       (AccelY),
    .AccelZ       (AccelZ),
    .clear        (clear),
    .FiltX        (FiltX),
    .FiltY        (FiltY),
    .FiltZ        (FiltZ),
    .filt_valid   (filt_valid),
    .motion       (motion)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Record every filt_valid pulse and the cycle it appeared in.
  always @(negedge CLOCK_50) begin
    if (filt_valid) begin
      fv_cnt  <= fv_cnt + 1;
      fv_prev <= fv_last;
      fv_last <= cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int x, input int y, input int z, input logic clr);
    sample_valid = 1'b1;
    clear        = clr;
    AccelX       = DW'(x);
    AccelY       = DW'(y);
    AccelZ       = DW'(z);
    @(posedge CLOCK_50);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic window(input int x, input int y, input int z);
    for (int i = 0; i < WIN; i++) strobe(x, y, z, 1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_filtx", int'(FiltX), 0);
    check("rst_filty", int'(FiltY), 0);
    check("rst_filtz", int'(FiltZ), 0);
    check("rst_fv", int'(filt_valid), 0);
    check("rst_motion", int'(motion), 0);
    RESET = 1'b0;
    idle(1);

    // Constant window, latency 1, hold between windows
    for (int i = 0; i < WIN - 1; i++) begin
      strobe(100, -200, 2047, 1'b0);
      check("fv_early", int'(filt_valid), 0);
    end
    strobe(100, -200, 2047, 1'b0);
    check("const_fv", int'(filt_valid), 1);
    check("const_x", int'(FiltX), 100);
    check("const_y", int'(FiltY), -200);
    check("const_z", int'(FiltZ), 2047);
    idle(1);
    check("const_fv_drop", int'(filt_valid), 0);
    idle(3);
    check("hold_x", int'(FiltX), 100);
    check("hold_z", int'(FiltZ), 2047);

    // Floor rounding
    strobe(1, 0, 0, 1'b0);
    for (int i = 1; i < WIN; i++) strobe(0, 0, 0, 1'b0);
    check("floor_pos_x", int'(FiltX), 0);
    strobe(-1, 0, 0, 1'b0);
    for (int i = 1; i < WIN; i++) strobe(0, 0, 0, 1'b0);
    check("floor_neg_x", int'(FiltX), -1);
    check("floor_neg_fv", int'(filt_valid), 1);

    // Reset mid-window discards the partial window
    idle(2);
    for (int i = 0; i < 5; i++) strobe(400, 0, 0, 1'b0);
    do_reset();
    check("midrst_x", int'(FiltX), 0);
    base = fv_cnt;
    window(8, 0, 0);
    check("midrst_win_x", int'(FiltX), 8);
    idle(2);
    check("midrst_pulses", fv_cnt - base, 1);

    // clear coincident with the 8th strobe
    base = fv_cnt;
    for (int i = 0; i < WIN - 1; i++) strobe(5, 0, 0, 1'b0);
    strobe(5, 0, 0, 1'b1);
    check("clr_fv", int'(filt_valid), 0);
    check("clr_hold_x", int'(FiltX), 8);
    window(-16, 0, 0);
    check("clr_next_x", int'(FiltX), -16);
    idle(2);
    check("clr_pulses", fv_cnt - base, 1);

    // Back-to-back strobes over two windows
    base = fv_cnt;
    for (int i = 0; i < 2 * WIN; i++) strobe(3, 0, 0, 1'b0);
    idle(2);
    check("b2b_pulses", fv_cnt - base, 2);
    check("b2b_spacing", fv_last - fv_prev, 8);
    check("b2b_x", int'(FiltX), 3);

    // Motion: FILL window never flags, RUN compares against threshold 64
    do_reset();
    window(0, 0, 0);
    check("mot_fill", int'(motion), 0);
    window(65, 0, 0);
`ifdef ACCEL_MOTION_DETECT_EN
    check("mot_65", int'(motion), 1);
`else
    check("mot_65", int'(motion), 0);
`endif
    idle(1);
    check("mot_drop", int'(motion), 0);
    window(1, 0, 0);
    check("mot_64_down", int'(motion), 0);
    do_reset();
    window(0, 0, 0);
    window(64, 0, 0);
    check("mot_64", int'(motion), 0);
    do_reset();
    window(2000, 0, 0);
    check("mot_first_big", int'(motion), 0);
    check("mot_first_x", int'(FiltX), 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
